// File: rtl/pool_pkg.sv
// Shared types and width helpers for the KxK stride-K streaming pooling engine.
package pool_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pool_state_e;

  // Accumulator width: K*K pixels summed needs 2*log2(K) guard bits.
  function automatic int acc_w(input int data_w, input int k);
    return data_w + 2 * $clog2(k);
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pool_stream_kxk_if.sv
// Control and valid/ready stream signals of the pooling engine.
interface pool_stream_kxk_if #(
  parameter int DATA_W = 16
);

  logic                     start;
  logic                     mode;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     busy;
  logic                     finish;

  modport master (
    output start, mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, finish
  );

  modport slave (
    input  start, mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, finish
  );

endinterface

// File: rtl/pool_line_buffer.sv
// One partial-window accumulator per output column; read and write share one index.
module pool_line_buffer #(
  parameter int DEPTH = 14,
  parameter int ACC_W = 18,
  parameter int IDX_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic        [IDX_W-1:0] idx,
  input  logic signed [ACC_W-1:0] wdata,
  output logic signed [ACC_W-1:0] rdata
);

  logic signed [ACC_W-1:0] mem [DEPTH];

  assign rdata = mem[idx];

  // NOTE: the array is reset because reset must clear it; a reset-free RAM would not meet that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

endmodule

// File: rtl/pool_stream_kxk.sv
// Streaming KxK stride-K average/max pooling: FSM, pixel counters, combine unit and
// a single output register with valid/ready backpressure.
module pool_stream_kxk
  import pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 2
) (
  input  logic             clk,
  input  logic             rst,
  pool_stream_kxk_if.slave bus
);

  localparam int LOG2K = $clog2(K);
  localparam int SHIFT = 2 * LOG2K;
  localparam int ACC_W = acc_w(DATA_W, K);
  localparam int DEPTH = IMG_W / K;
  localparam int IDX_W = idx_w(DEPTH);
  localparam int COL_W = idx_w(IMG_W);
  localparam int ROW_W = idx_w(IMG_H);

  pool_state_e state, state_next;
  pool_mode_e  mode_q;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic in_ready, accepted, finish;
  logic col_last, last_pix, win_first, win_last;

  logic signed [ACC_W-1:0]  pix_ext, acc_rd, acc_wr, acc_avg;
  logic signed [DATA_W-1:0] pooled;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]         lb_idx;

  assign col_last  = (col == COL_W'(IMG_W - 1));
  assign last_pix  = col_last && (row == ROW_W'(IMG_H - 1));
  assign win_first = (col[LOG2K-1:0] == '0) && (row[LOG2K-1:0] == '0);
  assign win_last  = (col[LOG2K-1:0] == '1) && (row[LOG2K-1:0] == '1);
  assign lb_idx    = IDX_W'(col >> LOG2K);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = (state == RUN) && !(out_valid && !bus.out_ready);
    accepted   = bus.in_valid && in_ready;
    finish     = 1'b0;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (accepted && last_pix) state_next = DRAIN;
      DRAIN: begin
        if (out_valid && bus.out_ready) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= POOL_AVG;
      col    <= '0;
      row    <= '0;
    end else if (state == IDLE && bus.start) begin
      mode_q <= pool_mode_e'(bus.mode);
      col    <= '0;
      row    <= '0;
    end else if (accepted) begin
      col <= col_last ? '0 : col + 1'b1;
      if (col_last) row <= last_pix ? '0 : row + 1'b1;
    end
  end

  pool_line_buffer #(
    .DEPTH (DEPTH),
    .ACC_W (ACC_W),
    .IDX_W (IDX_W)
  ) u_line_buffer (
    .clk   (clk),
    .rst   (rst),
    .we    (accepted),
    .idx   (lb_idx),
    .wdata (acc_wr),
    .rdata (acc_rd)
  );

  // The first pixel of a window overwrites whatever the previous window row band left.
  always_comb begin
    pix_ext = ACC_W'($signed(bus.in_data));
    acc_wr  = pix_ext;
    if (!win_first) begin
      if (mode_q == POOL_AVG) acc_wr = acc_rd + pix_ext;
      else                    acc_wr = (acc_rd > pix_ext) ? acc_rd : pix_ext;
    end
    acc_avg = acc_wr >>> SHIFT;
    pooled  = (mode_q == POOL_AVG) ? acc_avg[DATA_W-1:0] : acc_wr[DATA_W-1:0];
  end

  // Reload takes priority over the handshake clear so back-to-back results leave no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accepted && win_last) begin
      out_valid <= 1'b1;
      out_data  <= pooled;
    end else if (out_valid && bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.busy      = (state != IDLE);
  assign bus.finish    = finish;

endmodule

// File: tb/tb_pool_stream_kxk.sv
// Scoreboard bench for pool_stream_kxk on a 4x4 image with 2x2 windows.
module tb_pool_stream_kxk;
  import pool_pkg::*;

  typedef logic signed [15:0] frame_t [16];
  typedef logic signed [15:0] res_t   [4];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   fin_count = 0;
  logic signed [15:0] sb [$];

  pool_stream_kxk_if #(.DATA_W(16)) bus ();

  pool_stream_kxk #(
    .DATA_W (16),
    .IMG_W  (4),
    .IMG_H  (4),
    .K      (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each output handshake, away from the clock edge.
  always @(negedge clk) begin
    if (bus.finish) fin_count++;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got out_data=%0d with nothing expected", bus.out_data);
      end else begin
        check("out_data", int'(bus.out_data), int'(sb.pop_front()));
      end
    end
  end

  task automatic push_exp(input res_t r);
    for (int i = 0; i < 4; i++) sb.push_back(r[i]);
  endtask

  task automatic begin_frame(input pool_mode_e m);
    bus.start = 1'b1;
    bus.mode  = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
  endtask

  task automatic send_pix(input logic signed [15:0] p);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = p;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 100);
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input bit inject);
    logic orig_mode;
    orig_mode = bus.mode;
    for (int i = 0; i < 16; i++) begin
      if (inject && i == 3) begin
        bus.start = 1'b1;
        bus.mode  = ~orig_mode;
      end
      send_pix(f[i]);
      bus.start = 1'b0;
      bus.mode  = orig_mode;
    end
  endtask

  task automatic end_frame(input int fin_before);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.finish && n < 200);
    if (!bus.finish) check("finish_timeout", 0, 1);
    @(posedge clk); #1;
    check("busy_after_finish", int'(bus.busy), 0);
    check("out_valid_after_finish", int'(bus.out_valid), 0);
    check("finish_pulses", fin_count - fin_before, 1);
    check("sb_empty", sb.size(), 0);
  endtask

  task automatic run_frame(input pool_mode_e m, input frame_t f, input res_t r, input bit inject);
    int fb;
    fb = fin_count;
    push_exp(r);
    begin_frame(m);
    send_frame(f, inject);
    end_frame(fb);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  int'(bus.in_ready),  0);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_out_data"},  int'(bus.out_data),  0);
    check({tag, "_busy"},      int'(bus.busy),      0);
    check({tag, "_finish"},    int'(bus.finish),    0);
  endtask

  frame_t ramp, edge_f;
  res_t   avg_ramp, max_ramp, avg_edge, max_edge;

  initial begin
    for (int i = 0; i < 16; i++) ramp[i] = 16'(i);
    avg_ramp = '{16'sd2, 16'sd4, 16'sd10, 16'sd12};
    max_ramp = '{16'sd5, 16'sd7, 16'sd13, 16'sd15};
    edge_f = '{-16'sd1,  -16'sd2,  16'sd32767,  16'sd32767,
               -16'sd3,  -16'sd4,  16'sd32767,  16'sd32767,
               16'sd100, -16'sd100, -16'sd32768, -16'sd32768,
               16'sd7,   16'sd8,   -16'sd32768, -16'sd32768};
    avg_edge = '{-16'sd3, 16'sd32767, 16'sd3,   -16'sd32768};
    max_edge = '{-16'sd1, 16'sd32767, 16'sd100, -16'sd32768};

    bus.start     = 1'b0;
    bus.mode      = POOL_AVG;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(POOL_AVG, ramp,   avg_ramp, 1'b0);
    run_frame(POOL_MAX, ramp,   max_ramp, 1'b0);
    run_frame(POOL_AVG, edge_f, avg_edge, 1'b0);
    run_frame(POOL_MAX, edge_f, max_edge, 1'b0);

    // Hold the first result for five cycles; the input side must stall meanwhile.
    begin
      int fb;
      fb = fin_count;
      bus.out_ready = 1'b0;
      push_exp(avg_ramp);
      begin_frame(POOL_AVG);
      fork
        send_frame(ramp, 1'b0);
        begin
          int n = 0;
          do begin
            @(negedge clk);
            n++;
          end while (!bus.out_valid && n < 100);
          if (!bus.out_valid) check("out_valid_timeout", 0, 1);
          for (int i = 0; i < 5; i++) begin
            check("hold_out_data", int'(bus.out_data), 2);
            check("hold_in_ready", int'(bus.in_ready), 0);
            @(posedge clk); #1;
            if (i < 4) @(negedge clk);
          end
          bus.out_ready = 1'b1;
        end
      join
      end_frame(fb);
    end

    // Reset lands the cycle a result is presented; everything must clear immediately.
    begin_frame(POOL_AVG);
    for (int i = 0; i < 6; i++) send_pix(ramp[i]);
    check("pre_rst_out_valid", int'(bus.out_valid), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(POOL_AVG, ramp, avg_ramp, 1'b0);

    // start with a toggled mode during RUN must not disturb the frame.
    run_frame(POOL_AVG, ramp, avg_ramp, 1'b1);
    run_frame(POOL_MAX, ramp, max_ramp, 1'b1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
